oam_dma_ctrl: RTL and testbench

- Bus-sharing DMA controller between cpu6502 and the memory/peripheral bus.
- A CPU write of page number P to DMA_REG_ADDR starts the transfer. The controller halts the CPU via rdy, takes the bus, and copies 256 bytes from $P00-$PFF to the fixed port DEST_ADDR as alternating read/write bus cycles. It then returns the bus to the CPU.
- Sits between the cpu6502 address/data/rw pins and the rom/ram/peripheral decode.

---
 rtl/oam_dma_ctrl.sv | 155 +++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA bus-sharing controller between the CPU and the memory/peripheral bus
// Define OAM_DMA_ALIGN_EN to add a parity-driven ALIGN dummy read before the first transfer read.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_idata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw,
  output logic        rdy,
  output logic        busy
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE, DONE} state_t;
`endif

  state_t     state, state_nxt;
  logic       grant, grant_nxt;
  logic       rdy_nxt, busy_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] data, data_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 1'b0;
      rdy   <= 1'b1;
      busy  <= 1'b0;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      rdy   <= rdy_nxt;
      busy  <= busy_nxt;
      page  <= page_nxt;
      idx   <= idx_nxt;
      data  <= data_nxt;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (cycle_en) begin
      parity <= ~parity;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rdy_nxt   = rdy;
    busy_nxt  = busy;
    page_nxt  = page;
    idx_nxt   = idx;
    data_nxt  = data;
    if (cycle_en) begin
      case (state)
        IDLE: begin
          if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
            page_nxt  = cpu_odata;
            idx_nxt   = 8'h00;
            rdy_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = HALT;
          end
        end
        // CPU write cycles cannot be stalled, so wait for its first read cycle
        HALT: begin
          if (cpu_rw) begin
            grant_nxt = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
            state_nxt = parity ? ALIGN : READ;
`else
            state_nxt = READ;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: state_nxt = READ;
`endif
        READ: begin
          data_nxt  = bus_idata;
          state_nxt = WRITE;
        end
        // Bus and rdy return to the CPU for the DONE cycle; busy covers it too
        WRITE: begin
          if (idx == 8'hFF) begin
            grant_nxt = 1'b0;
            rdy_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 8'd1;
            state_nxt = READ;
          end
        end
        DONE: begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_odata = cpu_odata;
    bus_rw    = cpu_rw;
    if (grant) begin
      case (state)
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: begin
          bus_addr  = {page, 8'h00};
          bus_odata = data;
          bus_rw    = 1'b1;
        end
`endif
        READ: begin
          bus_addr  = {page, idx};
          bus_odata = data;
          bus_rw    = 1'b1;
        end
        WRITE: begin
          bus_addr  = DEST_ADDR;
          bus_odata = data;
          bus_rw    = 1'b0;
        end
        default: begin
          bus_addr  = cpu_addr;
          bus_odata = cpu_odata;
          bus_rw    = cpu_rw;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;
  localparam logic [15:0] STALL_A = 16'hC123;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cycle_en = 1'b0;
  logic [15:0] cpu_addr = 16'h1234;
  logic [7:0]  cpu_odata = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_idata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_odata;
  logic        bus_rw, rdy, busy;

  logic [7:0]  mem [0:65535];
  logic [31:0] cen_cnt;
  int          checks = 0;
  int          failures = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        rdy;
    logic        busy;
    logic        par;
  } ent_t;
  ent_t trace_q[$];

  always #5 clk = ~clk;
  assign bus_idata = mem[bus_addr];

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cycle_en(cycle_en),
    .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_rw(cpu_rw),
    .bus_idata(bus_idata), .bus_addr(bus_addr), .bus_odata(bus_odata),
    .bus_rw(bus_rw), .rdy(rdy), .busy(busy)
  );

  // Reference parity: number of bus cycles since reset
  always @(posedge clk or negedge reset)
    if (!reset) cen_cnt <= 0;
    else if (cycle_en) cen_cnt <= cen_cnt + 1;

  always @(negedge clk)
    if (reset && cycle_en)
      trace_q.push_back('{bus_addr, bus_odata, bus_rw, rdy, busy, cen_cnt[0]});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_addr = a; cpu_odata = d; cpu_rw = rw; cycle_en = 1'b0;
    @(posedge clk); #1 cycle_en = 1'b1;
    @(posedge clk); #1 cycle_en = 1'b0;
  endtask

  task automatic run_dma(input logic [7:0] pg, input int nwr);
    int n;
    trace_q.delete();
    cpu_cycle(16'h4014, pg, 1'b0);
    for (int k = 0; k < nwr; k++) cpu_cycle(16'h01FD - 16'(k), 8'(k), 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 1500) begin
      cpu_cycle(STALL_A, 8'h00, 1'b1);
      n++;
    end
    check_eq("dma_finish_in_budget", 32'(n < 1500), 1);
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] pg, input int h, output int first);
    int errs, busy_n, rdy_n;
    logic align;
    ent_t r, w;
    align = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
    if (h < trace_q.size()) align = trace_q[h].par;
`endif
    first = h + 1 + int'(align);
    check_eq({tag, "_len"}, trace_q.size(), first + 513);
    if (trace_q.size() < first + 513) return;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      r = trace_q[first + 2*i];
      w = trace_q[first + 2*i + 1];
      if (r.addr !== {pg, 8'(i)} || r.rw !== 1'b1) errs++;
      if (w.addr !== 16'h2004 || w.rw !== 1'b0 || w.odata !== mem[{pg, 8'(i)}]) errs++;
    end
    check_eq({tag, "_xfer_errs"}, errs, 0);
    busy_n = 0; rdy_n = 0;
    foreach (trace_q[k]) begin
      busy_n += int'(trace_q[k].busy);
      rdy_n  += int'(!trace_q[k].rdy);
    end
    check_eq({tag, "_busy_cycles"}, busy_n, first + 512);
    check_eq({tag, "_rdy_low_cycles"}, rdy_n, first + 511);
    check_eq({tag, "_done_addr"}, trace_q[first + 512].addr, STALL_A);
    check_eq({tag, "_done_rdy_busy"}, {trace_q[first + 512].rdy, trace_q[first + 512].busy}, 2'b11);
    if (align) check_eq({tag, "_align_addr"}, {trace_q[h + 1].addr, 7'd0, trace_q[h + 1].rw}, {pg, 8'h00, 8'h01});
  endtask

  initial begin
    logic [15:0] pt_a  [5];
    logic        pt_rw [5];
    int          f, n;

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0300 + 16'(i)] = ~8'(i);
      mem[16'hFF00 + 16'(i)] = 8'(i) ^ 8'h5A;
    end
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h00;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h97; mem[16'h8002] = 8'h55;

    // Reset state: bus follows CPU
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy_busy", {rdy, busy}, 2'b10);
    check_eq("rst_bus_addr", bus_addr, 16'h1234);
    check_eq("rst_bus_rw_odata", {bus_rw, bus_odata}, 9'h100);
    reset = 1'b1;

    // Passthrough: JMP $5597 then a store to $4015 that must not trigger
    pt_a  = '{16'h8000, 16'h8001, 16'h8002, 16'h5597, 16'h4015};
    pt_rw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    trace_q.delete();
    for (int i = 0; i < 5; i++) cpu_cycle(pt_a[i], 8'h3C, pt_rw[i]);
    check_eq("pt_len", trace_q.size(), 5);
    if (trace_q.size() == 5) begin
      for (int i = 0; i < 5; i++)
        check_eq($sformatf("pt_cycle%0d", i),
                 {trace_q[i].addr, 5'd0, trace_q[i].rw, trace_q[i].rdy, trace_q[i].busy},
                 {pt_a[i], 5'd0, pt_rw[i], 1'b1, 1'b0});
      check_eq("pt_write_data", trace_q[4].odata, 8'h3C);
    end

    // Basic transfer of page $02
    run_dma(8'h02, 0);
    check_eq("basic_trigger", {trace_q[0].addr, trace_q[0].odata, 6'd0, trace_q[0].rw, trace_q[0].rdy},
             {16'h4014, 8'h02, 6'd0, 1'b0, 1'b1});
    check_eq("basic_halt", {trace_q[1].addr, 6'd0, trace_q[1].rdy, trace_q[1].busy}, {STALL_A, 8'h01});
    check_xfer("basic", 8'h02, 1, f);
    check_eq("basic_first_read", trace_q[f].addr, 16'h0200);

    // Two CPU pushes keep HALT
    run_dma(8'h02, 2);
    check_eq("stall_push1", {trace_q[1].addr, 7'd0, trace_q[1].rw}, {16'h01FD, 8'h00});
    check_eq("stall_push2", {trace_q[2].addr, 7'd0, trace_q[2].rw}, {16'h01FC, 8'h00});
    check_eq("stall_halt_read", trace_q[3].addr, STALL_A);
    check_xfer("stall", 8'h02, 3, f);
    check_eq("stall_first_read", trace_q[f].addr, 16'h0200);

    // Page $FF including vectors
    run_dma(8'hFF, 0);
    check_xfer("pageff", 8'hFF, 1, f);
    if (trace_q.size() >= f + 513) begin
      check_eq("pageff_fffc", trace_q[f + 2*252 + 1].odata, 8'h00);
      check_eq("pageff_fffd", trace_q[f + 2*253 + 1].odata, 8'h00);
      check_eq("pageff_last_read", trace_q[f + 510].addr, 16'hFFFF);
      check_eq("pageff_last_write", trace_q[f + 511].addr, 16'h2004);
    end

    // Reset after 100 DMA cycles, then restart on page $03
    trace_q.delete();
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    n = 0;
    while (trace_q.size() < 102 && n < 300) begin
      cpu_cycle(STALL_A, 8'h00, 1'b1);
      n++;
    end
    check_eq("rstmid_granted", 32'(trace_q.size() == 102 && trace_q[101].addr !== STALL_A), 1);
    cpu_addr = 16'h8123; cpu_rw = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check_eq("rstmid_rdy_busy", {rdy, busy}, 2'b10);
    check_eq("rstmid_bus_addr", {bus_addr, 7'd0, bus_rw}, {16'h8123, 8'h01});
    @(posedge clk); #1 reset = 1'b1;
    run_dma(8'h03, 0);
    check_xfer("restart", 8'h03, 1, f);

`ifdef OAM_DMA_ALIGN_EN
    // Force odd parity on the HALT exit cycle
    if (cen_cnt[0] != 1'b0) cpu_cycle(STALL_A, 8'h00, 1'b1);
    run_dma(8'h02, 0);
    check_eq("align_parity", trace_q[1].par, 1);
    check_xfer("align", 8'h02, 1, f);
    check_eq("align_first_real_read", f, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
